// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier: one recoded digit of the zero-extended
// unsigned multiplier is retired per clock into a 2*DATA_WIDTH+2 bit accumulator.
module booth_seq_mult #(
   parameter  int DATA_WIDTH = 32,
   localparam int NUM_DIGITS = DATA_WIDTH / 2 + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_WIDTH-1:0]     multiplicand,
   input  logic [DATA_WIDTH-1:0]     multiplier,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [2*DATA_WIDTH-1:0]   product,
   output logic                      busy
);

   localparam int AW = 2 * DATA_WIDTH + 2;
   localparam int MW = DATA_WIDTH + 3;
   localparam int KW = $clog2(NUM_DIGITS + 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   logic [AW-1:0]   a_sh;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   term;
   logic [MW-1:0]   m_sh;
   logic [KW-1:0]   k;
   logic [2:0]      code;

   // Operands are pre-shifted each digit (A left by 2, M right by 2), so the
   // current digit is always M's low window and the term needs no variable shift.
   always_comb begin
      code = m_sh[2:0];
      term = '0;
      case (code)
         3'b001, 3'b010: term = a_sh;
         3'b011:         term = a_sh << 1;
         3'b100:         term = -(a_sh << 1);
         3'b101, 3'b110: term = -a_sh;
         default:        term = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         a_sh      <= '0;
         m_sh      <= '0;
         k         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh     <= {{(AW - DATA_WIDTH){1'b0}}, multiplicand};
                  m_sh     <= {2'b00, multiplier, 1'b0};
                  acc      <= '0;
                  k        <= '0;
                  state    <= CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            CALC: begin
               acc  <= acc + term;
               a_sh <= a_sh << 2;
               m_sh <= m_sh >> 2;
               k    <= k + KW'(1);
               if (k == KW'(NUM_DIGITS - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign product = acc[2*DATA_WIDTH-1:0];

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult: hand-computed products, handshake timing,
// output hold under back-pressure, and asynchronous reset mid-calculation.
module tb_booth_seq_mult;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   booth_seq_mult #(.DATA_WIDTH(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Latency is the cycle index in which out_valid is first seen high,
   // counting the cycle that ends with the accept edge as cycle 0.
   task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int hold);
      int cyc;
      cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("%s_ready", tag), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b1; multiplicand = a; multiplier = b;
      @(posedge clk); #1;
      in_valid = 1'b0; multiplicand = ~a; multiplier = ~b;
      check($sformatf("%s_busy", tag), {busy, in_ready}, 2'b10);
      cyc = 1;
      while (!out_valid && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
      end
      check($sformatf("%s_latency", tag), cyc, 18);
      check($sformatf("%s_product", tag), product, exp);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = (i == 3);
         multiplicand = 32'h0000_0011; multiplier = 32'h0000_0022;
         @(posedge clk); #1;
         check($sformatf("%s_hold%0d", tag, i), {in_ready, out_valid, busy, product},
               {3'b011, exp});
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check($sformatf("%s_retire", tag), {out_valid, in_ready, busy}, 3'b010);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      multiplicand = '0; multiplier = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_product", product, 64'h0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_mult("m3x5",    32'd3,          32'd5,          64'h0000_0000_0000_000F, 0);
      run_mult("mff_ff",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 0);
      run_mult("m8_aa",   32'h8000_0000,  32'hAAAA_AAAA,  64'h5555_5555_0000_0000, 0);
      run_mult("m0",      32'h0,          32'h1234_5678,  64'h0, 0);
      run_mult("mzero_b", 32'h1234_5678,  32'h0,          64'h0, 0);
      run_mult("m1_ff",   32'd1,          32'hFFFF_FFFF,  64'h0000_0000_FFFF_FFFF, 0);
      run_mult("mff_1",   32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF, 0);
      run_mult("m16_16",  32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000, 0);
      run_mult("mx2",     32'h1234_5678,  32'd2,          64'h0000_0000_2468_ACF0, 0);
      run_mult("mffff",   32'h0000_FFFF,  32'h0000_FFFF,  64'h0000_0000_FFFE_0001, 0);
      run_mult("mhold",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001, 10);

      // Reset asserted in CALC cycle 8 discards the operation.
      @(negedge clk);
      in_valid = 1'b1; multiplicand = 32'd3; multiplier = 32'd5;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_outputs", {in_ready, out_valid, busy, product}, {3'b100, 64'h0});
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("arst_no_emit", {out_valid, in_ready}, 2'b01);
      run_mult("m7x9",    32'd7,          32'd9,          64'd63, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
